// File: rtl/spike_injector.sv
// Spike injector: FIFO-buffered packet feeder for the swarm grid with stress/fault throttling,
// hysteresis and a refractory gap after each burst. Define SPIKE_INJ_STATS_EN for sent/stall counters.
module spike_injector #(
  parameter int DEPTH     = 16,
  parameter int STRESS_HI = 200,
  parameter int STRESS_LO = 150,
  parameter int BURST     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data_a,
  input  logic [7:0]               in_data_b,
  input  logic [7:0]               stress,
  input  logic                     fault_inject,
  output logic                     spike_valid,
  output logic [7:0]               spike_data_a,
  output logic [7:0]               spike_data_b,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     throttled
`ifdef SPIKE_INJ_STATS_EN
  ,
  output logic [15:0]              sent_count,
  output logic [15:0]              stall_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(BURST + 1);
  localparam logic [7:0] HI = 8'(STRESS_HI);
  localparam logic [7:0] LO = 8'(STRESS_LO);

  typedef enum logic [1:0] {RUN, GAP, THROTTLE} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   burst_cnt, burst_next;
  logic [PW-1:0]   wptr, rptr;
  logic [15:0]     mem [DEPTH];
  logic            push, pop, empty, throttle_req, release_ok;

  assign empty        = (level == '0);
  assign in_ready     = (level < LW'(DEPTH));
  assign push         = in_valid && in_ready;
  assign throttle_req = (stress > HI) || fault_inject;
  assign release_ok   = (stress < LO) && !fault_inject;
  assign throttled    = (state == THROTTLE);

  always_comb begin
    state_next = state;
    burst_next = burst_cnt;
    pop        = 1'b0;
    unique case (state)
      RUN: begin
        if (throttle_req) begin
          state_next = THROTTLE;
          burst_next = '0;
        end else if (!empty) begin
          pop = 1'b1;
          if (burst_cnt == BW'(BURST - 1)) begin
            state_next = GAP;
            burst_next = '0;
          end else begin
            burst_next = burst_cnt + 1'b1;
          end
        end else begin
          burst_next = '0;
        end
      end
      GAP: begin
        burst_next = '0;
        state_next = throttle_req ? THROTTLE : RUN;
      end
      THROTTLE: begin
        burst_next = '0;
        if (release_ok) state_next = RUN;
      end
      default: begin
        state_next = RUN;
        burst_next = '0;
      end
    endcase
  end

  // Storage carries no reset: pointers and level reset, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {in_data_a, in_data_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      burst_cnt    <= '0;
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      spike_valid  <= 1'b0;
      spike_data_a <= '0;
      spike_data_b <= '0;
    end else begin
      state       <= state_next;
      burst_cnt   <= burst_next;
      spike_valid <= pop;
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr                         <= rptr + 1'b1;
        {spike_data_a, spike_data_b} <= mem[rptr];
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef SPIKE_INJ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_count  <= '0;
      stall_count <= '0;
    end else begin
      if (spike_valid && sent_count != '1) sent_count <= sent_count + 1'b1;
      if (state == THROTTLE && !empty && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_injector.sv
// Directed self-checking bench for spike_injector; a packet queue tracks expected order and occupancy.
module tb_spike_injector;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data_a = '0;
  logic [7:0]  in_data_b = '0;
  logic [7:0]  stress = '0;
  logic        fault_inject = 1'b0;
  logic        spike_valid;
  logic [7:0]  spike_data_a;
  logic [7:0]  spike_data_b;
  logic [4:0]  level;
  logic        throttled;
`ifdef SPIKE_INJ_STATS_EN
  logic [15:0] sent_count;
  logic [15:0] stall_count;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          streak = 0;
  logic [15:0] exp_q[$];
  logic [14:0] pat;

  spike_injector #(.DEPTH(16), .STRESS_HI(200), .STRESS_LO(150), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_a(in_data_a), .in_data_b(in_data_b), .stress(stress),
    .fault_inject(fault_inject), .spike_valid(spike_valid),
    .spike_data_a(spike_data_a), .spike_data_b(spike_data_b),
    .level(level), .throttled(throttled)
`ifdef SPIKE_INJ_STATS_EN
    , .sent_count(sent_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; emitted packets are matched against the queue before new pushes join it.
  task automatic step();
    logic        pushed;
    logic [15:0] pdata;
    logic [15:0] e;
    pushed = in_valid && in_ready;
    pdata  = {in_data_a, in_data_b};
    @(posedge clk);
    #1;
    if (spike_valid) begin
      streak++;
      check("burst_len", int'(streak <= BURST), 1);
      if (exp_q.size() == 0) check("spurious_spike", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("spike_data", {spike_data_a, spike_data_b}, e);
      end
    end else streak = 0;
    if (pushed) exp_q.push_back(pdata);
    check("level", level, exp_q.size());
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    check("drain_empty", exp_q.size(), 0);
    step();
    check("drain_idle", spike_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values (asynchronous, before any clock edge)
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_data_a", spike_data_a, 0);
    check("rst_data_b", spike_data_b, 0);
    check("rst_level", level, 0);
    check("rst_throttled", throttled, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single packet latency
    in_valid = 1'b1; in_data_a = 8'h12; in_data_b = 8'h34;
    step();
    in_valid = 1'b0;
    check("single_level1", level, 1);
    check("single_no_spike_yet", spike_valid, 0);
    step();
    check("single_spike", spike_valid, 1);
    check("single_a", spike_data_a, 8'h12);
    check("single_b", spike_data_b, 8'h34);
    step();
    check("single_pulse_end", spike_valid, 0);
    check("single_in_ready", in_ready, 1);

    // Ten back-to-back packets: 4 on, 1 off, 4 on, 1 off, 2 on
    pat = 15'b001101111011110;
    for (int k = 0; k < 15; k++) begin
      in_valid  = (k < 10);
      in_data_a = 8'h40 + 8'(k);
      in_data_b = 8'hC0 + 8'(k);
      step();
      check("cadence", spike_valid, int'(pat[k]));
    end
    in_valid = 1'b0;
    check("cadence_empty", level, 0);

    // Throttle by stress, fill to full, hysteresis, release
    stress = 8'd210;
    step();
    check("stress_throttled", throttled, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data_a = 8'h20 + 8'(i);
      in_data_b = 8'hA0 + 8'(i);
      step();
      check("throttle_no_spike", spike_valid, 0);
    end
    check("full_level", level, 16);
    check("full_in_ready", in_ready, 0);
    in_data_a = 8'hEE; in_data_b = 8'hEE;
    step();
    check("full_reject_level", level, 16);
    in_valid = 1'b0;
    stress = 8'd180;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hyst_throttled", throttled, 1);
      check("hyst_no_spike", spike_valid, 0);
    end
    stress = 8'd149;
    step();
    check("release_throttled", throttled, 0);
    check("release_no_pop_yet", spike_valid, 0);
    step();
    check("release_first_pop", spike_valid, 1);
    stress = 8'd0;
    drain();

    // fault_inject for 3 cycles mid-burst
    for (int i = 0; i < 8; i++) begin
      in_valid     = 1'b1;
      in_data_a    = 8'h60 + 8'(i);
      in_data_b    = 8'h10 + 8'(i);
      fault_inject = (i >= 3 && i <= 5);
      step();
      if (i == 1 || i == 2) check("pre_fault_pop", spike_valid, 1);
      if (i >= 3 && i <= 5) begin
        check("fault_no_pop", spike_valid, 0);
        check("fault_throttled", throttled, 1);
      end
      if (i == 6) begin
        check("fault_exit", throttled, 0);
        check("fault_exit_no_pop", spike_valid, 0);
      end
      if (i == 7) check("fault_resume", spike_valid, 1);
    end
    in_valid = 1'b0;
    fault_inject = 1'b0;
    drain();

    // Simultaneous push and pop at level 5
    fault_inject = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data_a = 8'h80 + 8'(i);
      in_data_b = 8'h55;
      step();
    end
    in_valid = 1'b0;
    check("pp_level5", level, 5);
    fault_inject = 1'b0;
    step();
    check("pp_run", throttled, 0);
    in_valid = 1'b1; in_data_a = 8'h70; in_data_b = 8'h07;
    step();
    in_valid = 1'b0;
    check("pp_level_same", level, 5);
    check("pp_popped", spike_valid, 1);
    drain();

`ifdef SPIKE_INJ_STATS_EN
    rst = 1'b1;
    #1;
    exp_q.delete(); streak = 0;
    check("stats_rst_sent", sent_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    fault_inject = 1'b1;
    step();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data_a = 8'h90 + 8'(i); in_data_b = 8'h01;
      step();
    end
    in_valid = 1'b0;
    fault_inject = 1'b0;
    step();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data_a = 8'hB0 + 8'(i); in_data_b = 8'h02;
      step();
    end
    in_valid = 1'b0;
    drain();
    check("stats_sent", sent_count, 7);
    check("stats_stall", stall_count, 3);
`endif

    // Asynchronous reset mid-burst
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data_a = 8'hD0 + 8'(i); in_data_b = 8'h3C;
      if (i < 3) step();
    end
    check("midrst_busy", spike_valid, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    exp_q.delete(); streak = 0;
    check("midrst_spike_valid", spike_valid, 0);
    check("midrst_level", level, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_throttled", throttled, 0);
    check("midrst_data_a", spike_data_a, 0);
    check("midrst_data_b", spike_data_b, 0);
`ifdef SPIKE_INJ_STATS_EN
    check("midrst_sent", sent_count, 0);
    check("midrst_stall", stall_count, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    step();
    check("postrst_idle", spike_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
